rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 8x16 bypassed register file between two writeback sources.
- Primary source is the pipeline WB stage: fixed priority, no backpressure.
- Secondary source is the multicycle unit (mult/div). It uses a valid/ready handshake and a small holding FIFO.
- Provides a pending-write mask for the decode-stage scoreboard, and a stall request to the pipeline when a buffered write starves.

Parameters:
DEPTH, 2, holding FIFO entries; power of two, >= 2
MAX_WAIT, 4, cycles the FIFO head may wait before stall_req asserts; >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wb_valid  input  1  pipeline writeback request this cycle
wb_regsel  input  3  pipeline destination register
wb_data  input  16  pipeline writeback data
mc_valid  input  1  multicycle unit has a result
mc_regsel  input  3  multicycle destination register
mc_data  input  16  multicycle result data
mc_ready  output  1  FIFO can accept; transfer when mc_valid & mc_ready
write  output  1  register file write enable
writeregsel  output  3  register file write select
writedata  output  16  register file write data
pending_mask  output  8  bit r = 1 if any valid FIFO entry targets register r
stall_req  output  1  pipeline must bubble WB next cycle
err  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. All state updates on the posedge of clk.
- Reset effects:
  - FIFO is empty (pointers and count = 0); age = 0; err = 0.
  - While rst is high, write, mc_ready and stall_req are forced to 0; no enqueue occurs.
  - Contents of a partially filled FIFO are discarded and never written.
- Enqueue:
  - mc_ready = !full (and !rst).
  - On mc_valid & mc_ready, {mc_regsel, mc_data} is written at the tail.
  - When full, there is no enqueue even if a dequeue happens the same cycle.
- Write-port selection (combinational from inputs and FIFO head; the register file latches at the edge):
  - If wb_valid: write = 1, writeregsel = wb_regsel, writedata = wb_data.
  - Else if FIFO is non-empty: write = 1, FIFO head fields are driven, and the head is dequeued at the edge.
  - Else: write = 0; writeregsel and writedata are 0.
- No same-cycle bypass from mc inputs to the write port. Minimum mc-to-write latency is 1 cycle (accept in cycle N, write in N+1).
- Simultaneous enqueue and dequeue when not full: the count is unchanged and the pointers wrap modulo DEPTH.
- Age counter:
  - Resets to 0 on dequeue or when the FIFO is empty.
  - Otherwise increments each cycle the head is not drained, saturating at MAX_WAIT.
- stall_req = non-empty && (age >= MAX_WAIT).
- Pipeline contract: if stall_req = 1 in cycle N, wb_valid must be 0 in cycle N+1. The head then drains in N+1.
- Violation: stall_req registered high in cycle N and wb_valid = 1 in N+1 sets err = 1. err is sticky until rst. The primary source still wins in that cycle.
- pending_mask:
  - Combinational OR of one-hot(regsel) over valid entries.
  - An entry being dequeued this cycle still shows in the mask this cycle.
  - Entries targeting the same register drain in FIFO order.
- Writes to r0 are ordinary writes; r0 is not special.

Test Plan:
- Reset: assert rst 2 cycles with mc_valid = 1 -> write = 0, mc_ready = 0 during reset. After release: mc_ready = 1, pending_mask = 8'h00, stall_req = 0, err = 0.
- Single mc write, wb_valid = 0: mc r3 = 16'hBEEF accepted in cycle N -> N+1: write = 1, writeregsel = 3, writedata = 16'hBEEF, pending_mask = 8'h08. N+2: pending_mask = 0, write = 0.
- Contention:
  - Stimulus: wb_valid = 1 held writing r1; mc offers r2 = 16'h1111, then r4 = 16'h2222, then r5.
  - Required: two entries accepted, then mc_ready = 0, pending_mask = 8'h14, and every write cycle has writeregsel = 1.
- Starvation, MAX_WAIT = 4: wb_valid held high; entry enqueued in cycle N -> stall_req = 1 in N+5. Bench drops wb_valid in N+6 -> write r-head in N+6, then age = 0 and stall_req = 0.
- Violation: same as the starvation case, but wb_valid is kept high in N+6 -> err = 1 from N+7 and stays 1. The entry drains on the first cycle wb_valid = 0. err clears only after rst.
- Reset mid-operation: FIFO holding 2 entries, wb_valid = 0, rst pulsed 1 cycle -> no write of the flushed entries; pending_mask = 0 and mc_ready = 1 the cycle after rst.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single write port of the 8x16 register file between the
// pipeline WB stage (fixed priority, never back-pressured) and the
// multicycle unit (valid/ready into a small holding FIFO).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wb_valid/wb_regsel/wb_data      pipeline writeback request
//   mc_valid/mc_regsel/mc_data      multicycle result offer
//   mc_ready                        FIFO can accept this cycle
//   write/writeregsel/writedata     register file write port
//   pending_mask                    one bit per register with a buffered write
//   stall_req                       pipeline must bubble WB next cycle
//   err                             sticky: pipeline ignored stall_req
module rf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [2:0]  wb_regsel,
    input  logic [15:0] wb_data,
    input  logic        mc_valid,
    input  logic [2:0]  mc_regsel,
    input  logic [15:0] mc_data,
    output logic        mc_ready,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic [7:0]  pending_mask,
    output logic        stall_req,
    output logic        err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MAX_WAIT + 1);

    logic [2:0]       regsel_r [DEPTH];
    logic [15:0]      data_r   [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    age_r;
    logic             stall_d_r;
    logic             err_r;

    logic             empty_s;
    logic             full_s;
    logic             enq_s;
    logic             deq_s;
    logic             stall_s;
    logic             write_s;
    logic [2:0]       sel_s;
    logic [15:0]      data_s;
    logic [7:0]       mask_s;

    function automatic logic [7:0] onehot8(input logic [2:0] sel);
        onehot8 = 8'h01 << sel;
    endfunction

    // FIFO status, enqueue handshake and starvation stall
    always_comb begin
        empty_s = (count_r == {CW{1'b0}});
        full_s  = (count_r == CW'(DEPTH));
        // a full FIFO refuses even if the head drains this cycle
        enq_s   = mc_valid && !full_s && !rst;
        stall_s = !rst && !empty_s && (age_r >= AW'(MAX_WAIT));
    end

    // Write-port selection: pipeline first, then FIFO head, else idle
    always_comb begin
        write_s = 1'b0;
        sel_s   = 3'd0;
        data_s  = 16'h0000;
        deq_s   = 1'b0;
        if (rst) begin
            write_s = 1'b0;
        end else if (wb_valid) begin
            write_s = 1'b1;
            sel_s   = wb_regsel;
            data_s  = wb_data;
        end else if (!empty_s) begin
            write_s = 1'b1;
            sel_s   = regsel_r[rd_ptr_r];
            data_s  = data_r[rd_ptr_r];
            deq_s   = 1'b1;
        end else begin
            write_s = 1'b0;
        end
    end

    // Pending-write mask: the entry leaving this cycle is still shown
    always_comb begin
        mask_s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            mask_s = mask_s | (vld_r[i] ? onehot8(regsel_r[i]) : 8'h00);
        end
    end

    // FIFO storage, pointers, valid bits and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            vld_r    <= {DEPTH{1'b0}};
        end else begin
            // enqueue only when not full, so wr_ptr never equals a draining rd_ptr
            if (deq_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r        <= rd_ptr_r + PW'(1);
            end
            if (enq_s) begin
                regsel_r[wr_ptr_r] <= mc_regsel;
                data_r[wr_ptr_r]   <= mc_data;
                vld_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r           <= wr_ptr_r + PW'(1);
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head age: cycles the current head has been passed over, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            age_r <= {AW{1'b0}};
        end else if (deq_s || empty_s) begin
            age_r <= {AW{1'b0}};
        end else if (age_r < AW'(MAX_WAIT)) begin
            age_r <= age_r + AW'(1);
        end else begin
            age_r <= age_r;
        end
    end

    // Protocol watchdog: WB write in the cycle after a stall request
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_d_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            stall_d_r <= stall_s;
            if (stall_d_r && wb_valid) begin
                err_r <= 1'b1;
            end
        end
    end

    assign mc_ready     = !full_s && !rst;
    assign write        = write_s;
    assign writeregsel  = sel_s;
    assign writedata    = data_s;
    assign pending_mask = mask_s;
    assign stall_req    = stall_s;
    assign err          = err_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based reference model predicts
// each cycle's write-port contents and status outputs; a monitor thread
// compares them with the DUT on the falling edge.
module tb_rf_wb_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [2:0]  wb_regsel;
    logic [15:0] wb_data;
    logic        mc_valid;
    logic [2:0]  mc_regsel;
    logic [15:0] mc_data;
    logic        mc_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [7:0]  pending_mask;
    logic        stall_req;
    logic        err;

    rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_regsel(wb_regsel), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_regsel(mc_regsel), .mc_data(mc_data),
        .mc_ready(mc_ready), .write(write), .writeregsel(writeregsel),
        .writedata(writedata), .pending_mask(pending_mask),
        .stall_req(stall_req), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       write;
        logic       mc_ready;
        logic       stall;
        logic       err;
        logic [7:0] mask;
    } ctl_t;

    ctl_t        ctl_q[$];
    logic [18:0] wq[$];      // expected {regsel, data} in write order

    // reference model state
    logic [18:0] m_q[$];     // buffered multicycle results, oldest first
    int          m_wait;     // cycles the head has been passed over
    logic        m_err;
    logic        m_prev_stall;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's prediction for it
    task automatic step(input logic r, input logic wv, input logic [2:0] wr, input logic [15:0] wd,
                        input logic mv, input logic [2:0] mr, input logic [15:0] md);
        ctl_t c;
        logic deq;
        logic was_empty;
        @(posedge clk);
        #1;
        rst = r; wb_valid = wv; wb_regsel = wr; wb_data = wd;
        mc_valid = mv; mc_regsel = mr; mc_data = md;

        c.mc_ready = !r && (m_q.size() < DEPTH);
        c.stall    = !r && (m_q.size() > 0) && (m_wait >= MAX_WAIT);
        c.err      = m_err;
        c.mask     = 8'h00;
        foreach (m_q[i]) c.mask[m_q[i][18:16]] = 1'b1;
        c.write    = 1'b0;
        if (!r && wv) begin
            c.write = 1'b1;
            wq.push_back({wr, wd});
        end else if (!r && m_q.size() > 0) begin
            c.write = 1'b1;
            wq.push_back(m_q[0]);
        end
        ctl_q.push_back(c);

        // state after the clock edge
        if (r) begin
            m_q.delete();
            m_wait = 0;
            m_err = 1'b0;
            m_prev_stall = 1'b0;
        end else begin
            if (m_prev_stall && wv) m_err = 1'b1;
            was_empty = (m_q.size() == 0);
            deq = !wv && !was_empty;
            if (deq) void'(m_q.pop_front());
            if (deq || was_empty) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            if (mv && c.mc_ready) m_q.push_back({mr, md});
            m_prev_stall = c.stall;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic monitor();
        ctl_t c;
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                chk("write", 32'(write), 32'(c.write));
                chk("mc_ready", 32'(mc_ready), 32'(c.mc_ready));
                chk("stall_req", 32'(stall_req), 32'(c.stall));
                chk("err", 32'(err), 32'(c.err));
                chk("pending_mask", 32'(pending_mask), 32'(c.mask));
                if (write) begin
                    if (wq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %0h expected none at %0t",
                                 {writeregsel, writedata}, $time);
                    end else begin
                        e = wq.pop_front();
                        chk("write_port", 32'({writeregsel, writedata}), 32'(e));
                    end
                end else begin
                    chk("idle_port", 32'({writeregsel, writedata}), 32'h0);
                end
            end
        end
    endtask

    initial begin
        logic r, wv, mv;
        rst = 1'b1; wb_valid = 1'b0; wb_regsel = 3'd0; wb_data = 16'h0;
        mc_valid = 1'b0; mc_regsel = 3'd0; mc_data = 16'h0;
        m_wait = 0; m_err = 1'b0; m_prev_stall = 1'b0;
        fork
            monitor();
        join_none

        // reset with mc_valid asserted: nothing accepted or written
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hDEAD);
        sample(); chk("rst_ready", 32'(mc_ready), 32'd0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hDEAD);
        idle(1);
        sample();
        chk("post_rst_ready", 32'(mc_ready), 32'd1);
        chk("post_rst_mask", 32'(pending_mask), 32'h00);
        chk("post_rst_err", 32'(err), 32'd0);

        // single mc write, one cycle latency
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hBEEF);
        idle(1);
        sample();
        chk("single_mask", 32'(pending_mask), 32'h08);
        chk("single_sel", 32'({write, writeregsel, writedata}), {13'h0, 1'b1, 3'd3, 16'hBEEF});
        idle(1);
        sample();
        chk("single_drained", 32'({write, pending_mask}), 32'h0);

        // contention, then starvation stall and drain
        step(1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'h1111);
        step(1'b0, 1'b1, 3'd1, 16'hA002, 1'b1, 3'd4, 16'h2222);
        step(1'b0, 1'b1, 3'd1, 16'hA003, 1'b1, 3'd5, 16'h3333);
        sample();
        chk("cont_full", 32'(mc_ready), 32'd0);
        chk("cont_mask", 32'(pending_mask), 32'h14);
        chk("cont_sel", 32'(writeregsel), 32'd1);
        step(1'b0, 1'b1, 3'd1, 16'hA004, 1'b0, 3'd0, 16'h0);
        step(1'b0, 1'b1, 3'd1, 16'hA005, 1'b0, 3'd0, 16'h0);
        sample(); chk("stall_early", 32'(stall_req), 32'd0);
        step(1'b0, 1'b1, 3'd1, 16'hA006, 1'b0, 3'd0, 16'h0);
        sample(); chk("stall_at_n5", 32'(stall_req), 32'd1);
        idle(1);
        sample();
        chk("drain_head", 32'({writeregsel, writedata}), {13'h0, 3'd2, 16'h1111});
        idle(2);
        sample(); chk("no_violation", 32'(err), 32'd0);

        // violation: WB kept high after stall_req
        step(1'b0, 1'b1, 3'd0, 16'h0B00, 1'b1, 3'd6, 16'h5A5A);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 3'd0, 16'(16'h0B00 + i), 1'b0, 3'd0, 16'h0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        sample();
        chk("err_set", 32'(err), 32'd1);
        chk("violation_drain", 32'({writeregsel, writedata}), {13'h0, 3'd6, 16'h5A5A});
        idle(2);
        sample(); chk("err_sticky", 32'(err), 32'd1);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        idle(1);
        sample(); chk("err_cleared", 32'(err), 32'd0);

        // reset mid-operation with two buffered entries
        step(1'b0, 1'b1, 3'd0, 16'hC000, 1'b1, 3'd1, 16'h1234);
        step(1'b0, 1'b1, 3'd0, 16'hC001, 1'b1, 3'd2, 16'h5678);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        idle(1);
        sample();
        chk("flush_mask", 32'(pending_mask), 32'h00);
        chk("flush_ready", 32'(mc_ready), 32'd1);
        chk("flush_nowrite", 32'(write), 32'd0);

        // randomized traffic, mostly honouring stall_req
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            wv = m_prev_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 4);
            mv = ($urandom_range(0, 9) < 6);
            step(r, wv, 3'($urandom), 16'($urandom), mv, 3'($urandom), 16'($urandom));
        end
        idle(6);
        sample();
        chk("queue_empty", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
